// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with write-to-read bypass and per-register busy scoreboard
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] R2_INIT = 2,
  parameter logic [XLEN-1:0] R3_INIT = 3,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush,
  output logic [AW:0]     busy_cnt,
  output logic            any_busy
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic [AW:0] cnt_nxt;
  logic hit1, hit2;
  assign hit1 = wr_en && wr_addr == rd_addr1;
  assign hit2 = wr_en && wr_addr == rd_addr2;
  assign rd_data1 = rd_addr1 == '0 ? '0 : hit1 ? wr_data : regs[rd_addr1];
  assign rd_data2 = rd_addr2 == '0 ? '0 : hit2 ? wr_data : regs[rd_addr2];
  // busy[0] is never set, so r0 needs no special case here
  assign rd_busy1 = busy[rd_addr1] && !hit1 && !flush;
  assign rd_busy2 = busy[rd_addr2] && !hit2 && !flush;
  assign any_busy = busy_cnt != '0;
  always_comb begin
    busy_nxt = '0;
    cnt_nxt = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_nxt[r] = flush ? 1'b0 :
                    (iss_en && iss_addr == AW'(r)) ? 1'b1 :
                    (wr_en && wr_addr == AW'(r)) ? 1'b0 : busy[r];
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= r == 2 ? R2_INIT : r == 3 ? R3_INIT : '0;
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array-based reference model
module tb_regfile_sb;
  logic clk = 0, reset = 1;
  logic [4:0] rd_addr1 = 0, rd_addr2 = 0, wr_addr = 0, iss_addr = 0;
  logic [63:0] rd_data1, rd_data2, wr_data = 0;
  logic rd_busy1, rd_busy2, wr_en = 0, iss_en = 0, flush = 0, any_busy;
  logic [5:0] busy_cnt;
  int total = 0, bad = 0;
  logic [63:0] m_reg [32];
  bit m_busy [32];

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(busy_cnt), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return a != 0 && m_busy[a] && !(wr_en && wr_addr == a) && !flush;
  endfunction

  // apply one cycle of inputs and check the combinational read ports against the model
  task automatic drv(input bit we, input logic [4:0] wa, input logic [63:0] wd,
                     input bit ie, input logic [4:0] ia, input bit fl, input bit rs,
                     input logic [4:0] a1, input logic [4:0] a2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl; reset = rs;
    rd_addr1 = a1; rd_addr2 = a2;
    #2;
    chk("rd_data1", rd_data1, exp_data(a1));
    chk("rd_data2", rd_data2, exp_data(a2));
    chk("rd_busy1", 64'(rd_busy1), 64'(exp_busy(a1)));
    chk("rd_busy2", 64'(rd_busy2), 64'(exp_busy(a2)));
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    #1;
    if (reset) begin
      foreach (m_reg[i]) begin
        m_reg[i] = i == 2 ? 64'd2 : i == 3 ? 64'd3 : 64'd0;
        m_busy[i] = 0;
      end
    end else if (flush) begin
      if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr] = wr_data;
        m_busy[wr_addr] = 0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
    c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    chk("busy_cnt", 64'(busy_cnt), 64'(c));
    chk("any_busy", 64'(any_busy), 64'(c != 0));
  endtask

  initial begin
    tick();
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    for (int i = 0; i < 16; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 5'(2 * i), 5'(2 * i + 1));
      chk("t1_even", rd_data1, i == 1 ? 64'd2 : 64'd0);
      chk("t1_odd", rd_data2, i == 1 ? 64'd3 : 64'd0);
      tick();
    end
    drv(1, 5, 64'hDEAD, 0, 0, 0, 0, 5, 0);
    chk("t2_bypass", rd_data1, 64'hDEAD);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 5, 5);
    chk("t2_array", rd_data1, 64'hDEAD);
    chk("t2_port2", rd_data2, 64'hDEAD);
    tick();
    drv(1, 0, 64'hFFFF, 1, 0, 0, 0, 0, 0);
    chk("t3_r0", rd_data1, 64'd0);
    chk("t3_r0_busy", 64'(rd_busy1), 64'd0);
    tick();
    chk("t3_cnt", 64'(busy_cnt), 64'd0);
    drv(0, 0, 0, 1, 7, 0, 0, 7, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 7, 7);
    chk("t4_busy", 64'(rd_busy1), 64'd1);
    chk("t4_cnt", 64'(busy_cnt), 64'd1);
    drv(1, 7, 64'h42, 0, 0, 0, 0, 7, 0);
    chk("t4_bypass_busy", 64'(rd_busy1), 64'd0);
    chk("t4_bypass_data", rd_data1, 64'h42);
    tick();
    chk("t4_cnt_after", 64'(busy_cnt), 64'd0);
    drv(0, 0, 0, 1, 9, 0, 0, 0, 0);
    tick();
    drv(1, 9, 64'h11, 1, 9, 0, 0, 9, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("t5_data", rd_data1, 64'h11);
    chk("t5_busy", 64'(rd_busy1), 64'd1);
    chk("t5_cnt", 64'(busy_cnt), 64'd1);
    drv(1, 9, 64'h12, 0, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 4, 0, 0, 4, 0);
    tick();
    drv(0, 0, 0, 1, 6, 0, 0, 6, 4);
    tick();
    drv(0, 0, 0, 1, 8, 0, 0, 8, 6);
    tick();
    chk("t6_cnt3", 64'(busy_cnt), 64'd3);
    chk("t6_any", 64'(any_busy), 64'd1);
    drv(1, 6, 64'h5, 1, 10, 1, 0, 4, 10);
    chk("t6_flush_busy", 64'(rd_busy1), 64'd0);
    tick();
    chk("t6_cnt0", 64'(busy_cnt), 64'd0);
    chk("t6_any0", 64'(any_busy), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 6, 10);
    chk("t6_r6", rd_data1, 64'h5);
    chk("t6_r10_busy", 64'(rd_busy2), 64'd0);
    drv(1, 11, 64'h9, 1, 12, 0, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 11, 2);
    chk("t6_r11_reset", rd_data1, 64'd0);
    chk("t6_r2_reset", rd_data2, 64'd2);
    tick();
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 2) != 0, 5'($urandom), {$urandom, $urandom},
          $urandom_range(0, 9) < 4, 5'($urandom), $urandom_range(0, 29) == 0,
          $urandom_range(0, 99) == 0, 5'($urandom), 5'($urandom));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
